tx_uart: RTL
============

Name: tx_uart

Overview:
UART transmitter; the transmit-side counterpart of the team's UART receiver, sharing the same 16x oversampled baud-tick generator.
- Accepts a parallel byte with a one-cycle start strobe.
- Serialises it LSB-first as start bit, NB_DATA data bits, then stop, each bit held for 16 baud ticks (stop held SB_TICK ticks).
- Reports completion with a single-cycle done tick.

Parameters:
NB_DATA, 8, data bits per frame (5..8)
SB_TICK, 16, baud ticks in stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
NB_TICK, 5, tick counter width; must hold max(15, SB_TICK-1)
NB_DCNT, 3, data-bit counter width; must hold NB_DATA-1

Ports:
i_clock  in  1  system clock; all state changes on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_tick  in  1  16x baud tick from baud-rate generator, one i_clock wide
i_tx_start  in  1  start strobe; sampled only in IDLE
i_data  in  NB_DATA  byte to send; captured on accepted start
o_tx  out  1  serial line, idle high
o_tx_done_tick  out  1  one-cycle pulse at frame end
o_busy  out  1  high from accepted start until frame end

Behaviour:
- Reset (i_reset_n=0, asynchronous): state=IDLE, o_tx=1, o_tx_done_tick=0, o_busy=0, counters=0, shift register=0.
- Reset mid-frame aborts the frame immediately: o_tx returns to 1 asynchronously and no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine: IDLE, START, DATA, STOP; 2-bit encoding; any illegal code goes to IDLE.
- IDLE:
  - o_tx=1.
  - On i_tx_start=1 at an edge: capture i_data into the shift register, clear tick counter, state=START.
  - From that same edge: o_tx=0, o_busy=1.
  - i_tick is irrelevant for acceptance.
- START:
  - Tick counter increments on each i_tick.
  - When i_tick=1 and count=15: count=0, data counter=0, state=DATA, o_tx=shift[0].
- DATA:
  - o_tx holds the current LSB.
  - When i_tick=1 and count=15: shift right by one and count=0.
  - If data counter=NB_DATA-1, state=STOP and o_tx=1; otherwise data counter increments and o_tx takes the next bit.
- STOP:
  - o_tx=1.
  - When i_tick=1 and count=SB_TICK-1: state=IDLE, o_busy=0, o_tx_done_tick=1 for exactly the next cycle (the first IDLE cycle).
- i_tx_start while o_busy=1 is ignored, and i_data changes during a frame have no effect.
- i_tx_start in the cycle o_tx_done_tick is high is accepted (back-to-back frames, no extra idle gap).
- Cycles without i_tick hold all state; no timeout.
- Frame length in ticks: 16*(1+NB_DATA)+SB_TICK. With i_tick every cycle, NB_DATA=8, SB_TICK=16: 160 cycles from acceptance edge to done pulse.
- Counters wrap only by explicit clear; the tick counter never exceeds max(15, SB_TICK-1).

Optional Feature:
TX_PARITY_EN
- Defined:
  - Adds state PARITY between DATA and STOP (3-bit state encoding) and a parameter PARITY_ODD (default 0).
  - Parity bit = XOR of captured data, inverted if PARITY_ODD=1.
  - Computed at capture and held for 16 ticks.
  - Frame grows by 16 ticks (176 cycles with i_tick every cycle).
- Undefined: no parity state, register or parameter; behaviour exactly as above.

Test Plan:
- Reset: hold i_reset_n=0, toggle i_tx_start -> o_tx=1, o_busy=0, o_tx_done_tick=0 throughout.
- Single frame, i_tick every cycle, i_data=8'hA5, start at cycle 0:
  - Required o_tx: 0 for cycles 0-15, then bits 1,0,1,0,0,1,0,1 each for 16 cycles, then 1 for 16 cycles.
  - Done pulse at cycle 160; o_busy low from cycle 160.
- Back-to-back, i_tick every 4th cycle:
  - Send 8'h00, then assert start with 8'hFF in the done cycle.
  - Required: second start bit begins immediately with no idle-high gap; two done pulses 640 cycles apart.
- Busy rejection: start 8'h3C, then pulse i_tx_start with 8'hC3 at cycle 50 -> only 8'h3C transmitted, one done pulse.
- Reset mid-frame: assert i_reset_n=0 during data bit 3 -> o_tx=1 immediately, no done pulse; a later start with 8'h81 transmits correctly.
- TX_PARITY_EN defined, PARITY_ODD=0, i_data=8'h07 -> parity bit 1 for cycles 144-159, stop bit 160-175, done at 176.

Source files
------------

// File: rtl/tx_uart.sv
// UART transmitter driven by a 16x oversampled baud tick.
// A frame is a start bit, NB_DATA data bits sent LSB-first, then a stop period
// of SB_TICK ticks. Every other bit lasts 16 ticks. All outputs are registered.
// Optional feature macro: TX_PARITY_EN adds a parity bit between the data bits
// and the stop period. PARITY_ODD selects odd parity.
module tx_uart #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned NB_TICK = 5,
    parameter int unsigned NB_DCNT = 3
`ifdef TX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_busy
);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    localparam logic [NB_TICK-1:0] TickLast = NB_TICK'(15);
    localparam logic [NB_TICK-1:0] StopLast = NB_TICK'(SB_TICK - 1);
    localparam logic [NB_DCNT-1:0] DcntLast = NB_DCNT'(NB_DATA - 1);

    state_e             state_q, state_d;
    logic [NB_TICK-1:0] tick_q, tick_d;
    logic [NB_DCNT-1:0] dcnt_q, dcnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // State and output registers; reset returns the line to idle-high at once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            dcnt_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dcnt_q  <= dcnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the registered line value is computed one edge ahead.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        dcnt_d  = dcnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_tx_start) begin
                    shift_d = i_data;
                    tick_d  = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef TX_PARITY_EN
                    par_d   = (^i_data) ^ PARITY_ODD;
`endif
                end
            end
            StStart: begin
                if (i_tick) begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        dcnt_d  = '0;
                        state_d = StData;
                        tx_d    = shift_q[0];
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
            StData: begin
                if (i_tick) begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (dcnt_q == DcntLast) begin
`ifdef TX_PARITY_EN
                            state_d = StParity;
                            tx_d    = par_q;
`else
                            state_d = StStop;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            dcnt_d = dcnt_q + NB_DCNT'(1);
                            tx_d   = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
`ifdef TX_PARITY_EN
            StParity: begin
                if (i_tick) begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (i_tick) begin
                    if (tick_q == StopLast) begin
                        tick_d  = '0;
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done_q;
    assign o_busy         = busy_q;

endmodule
